// File: rtl/spi_adc_rx.sv
//------------------------------------------------------------------------------
// spi_adc_rx
//
// SPI master receiver for a serial ADC (CPOL=0). Each frame pulls nCS low,
// produces FRAME_BITS sck periods and samples miso MSB-first on every sck
// rising edge. When the frame ends, the received word is shifted right by
// DATA_SHIFT and truncated to DATA_BITS, then presented on dout with a
// one-cycle valid pulse.
//
// A frame starts on a start pulse or on a periodic tick while auto_en is high.
// One trigger that arrives during a frame is held and served after the gap.
// Any further trigger during that frame is dropped.
//
// Timing, in clk cycles:
//   SETUP : DIV cycles with nCS low and sck low
//   SHIFT : 2*DIV*FRAME_BITS cycles; sck starts low and toggles every DIV
//   GAP   : GAP cycles with nCS high, busy still high
//
// Parameters:
//   DIV        sck half-period in clk cycles (1..255)
//   FRAME_BITS sck rising edges per frame (2..32)
//   DATA_BITS  width of dout (DATA_BITS + DATA_SHIFT <= FRAME_BITS)
//   DATA_SHIFT trailing received bits discarded
//   GAP        minimum nCS-high cycles between frames (>= 1)
//   PERIOD     clk cycles between auto-mode frame starts (>= 1)
//
// Ports:
//   clk      system clock; all logic runs on its rising edge
//   rst      asynchronous active-high reset
//   start    single-frame request, sampled every clk
//   auto_en  high = free-running conversions every PERIOD cycles
//   nCS      active-low chip select to the ADC
//   sck      serial clock to the ADC, idles low
//   miso     serial data from the ADC
//   dout     last complete sample
//   valid    one-cycle pulse when dout updates
//   busy     high from frame start until the end of the gap
//   overrun  (only with SPI_ADC_RX_OVERRUN_EN) sticky flag, set when a
//            trigger is dropped and cleared only by rst
//
// Optional feature macro: SPI_ADC_RX_OVERRUN_EN
//------------------------------------------------------------------------------
module spi_adc_rx #(
   parameter int DIV        = 2,
   parameter int FRAME_BITS = 16,
   parameter int DATA_BITS  = 13,
   parameter int DATA_SHIFT = 3,
   parameter int GAP        = 4,
   parameter int PERIOD     = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 auto_en,
   output logic                 nCS,
   output logic                 sck,
   input  logic                 miso,
   output logic [DATA_BITS-1:0] dout,
   output logic                 valid,
   output logic                 busy
`ifdef SPI_ADC_RX_OVERRUN_EN
   ,
   output logic                 overrun
`endif
);

   // Counter widths, each at least 1 bit so that degenerate parameters still
   // elaborate.
   localparam int DIV_W = (DIV > 1)    ? $clog2(DIV)    : 1;
   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam int GAP_W = (GAP > 1)    ? $clog2(GAP)    : 1;
   localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t                state;
   state_t                next_state;

   logic [DIV_W-1:0]      phase_cnt;   // clk cycles within the current sck half-period
   logic [BIT_W-1:0]      bit_cnt;     // sck rising edges so far in this frame
   logic [GAP_W-1:0]      gap_cnt;     // clk cycles spent in GAP
   logic [FRAME_BITS-1:0] shift_reg;

   logic                  auto_q;      // auto_en delayed by one cycle, for rise detection
   logic [PER_W-1:0]      period_cnt;
   logic                  tick;        // auto-mode conversion request
   logic                  pending;     // one trigger held while busy

   logic                  phase_end;
   logic                  gap_end;
   logic                  trigger;
   logic                  sample_en;
   logic                  frame_done;

   assign phase_end = (phase_cnt == DIV_W'(DIV - 1));
   assign gap_end   = (gap_cnt == GAP_W'(GAP - 1));
   // A start and a tick in the same cycle merge into a single trigger.
   assign trigger   = start | tick;

   //---------------------------------------------------------------------------
   // Auto-mode period counter.
   // The first tick comes in the cycle after auto_en is first seen high.
   // Every later tick comes PERIOD cycles after the previous one.
   // Dropping auto_en clears the counter. Any frame in progress and any
   // pending trigger are left alone.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auto_q     <= 1'b0;
         period_cnt <= '0;
         tick       <= 1'b0;
      end else begin
         // NOTE: clocked state is always updated with non-blocking assignments,
         // so every flop in this edge sees the values from before the edge.
         auto_q <= auto_en;
         if (!auto_en) begin
            period_cnt <= '0;
            tick       <= 1'b0;
         end else if (!auto_q || period_cnt == '0) begin
            period_cnt <= PER_W'(PERIOD - 1);
            tick       <= 1'b1;
         end else begin
            period_cnt <= period_cnt - 1'b1;
            tick       <= 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   //---------------------------------------------------------------------------
   // FSM next-state and per-cycle strobes.
   // In SHIFT, each half-period boundary does one of three things:
   //   sck low           -> this edge drives sck high, so sample miso
   //   sck high, more    -> ordinary falling edge
   //   sck high, last    -> frame complete
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      next_state = state;
      sample_en  = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (trigger || pending) begin
               next_state = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (phase_end) begin
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (phase_end) begin
               if (!sck) begin
                  sample_en = 1'b1;
               end else if (bit_cnt == BIT_W'(FRAME_BITS)) begin
                  frame_done = 1'b1;
                  next_state = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_end) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath and registered outputs.
   // nCS, busy and sck are decoded from next_state so that they change on the
   // same edge as the state itself. They come straight from flops, so they
   // never glitch.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nCS       <= 1'b1;
         sck       <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         dout      <= '0;
         phase_cnt <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         // NOTE: the shift register is cleared by reset like every other flop.
         // It is only a frame wide, and a known value keeps post-reset
         // behaviour deterministic.
         shift_reg <= '0;
         pending   <= 1'b0;
      end else begin
         nCS   <= !(next_state == ST_SETUP || next_state == ST_SHIFT);
         busy  <= (next_state != ST_IDLE);
         valid <= frame_done;

         if (frame_done) begin
            dout <= shift_reg[DATA_SHIFT +: DATA_BITS];
         end

         // Half-period counter: restarts on every state change and on every
         // sck toggle boundary. It only runs in SETUP and SHIFT.
         if (next_state != state || phase_end) begin
            phase_cnt <= '0;
         end else if (state == ST_SETUP || state == ST_SHIFT) begin
            phase_cnt <= phase_cnt + 1'b1;
         end

         // sck is low everywhere outside SHIFT, including on the exit edge.
         if (next_state != ST_SHIFT) begin
            sck <= 1'b0;
         end else if (state == ST_SHIFT && phase_end) begin
            sck <= !sck;
         end

         if (state == ST_SETUP) begin
            bit_cnt <= '0;
         end else if (sample_en) begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (sample_en) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], miso};
         end

         if (state == ST_GAP && !gap_end) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end

         // In IDLE, any held trigger is consumed by the transition to SETUP.
         // While busy, the first trigger is held. Later ones fall on an
         // already-set flag and are lost.
         if (state == ST_IDLE) begin
            pending <= 1'b0;
         end else if (trigger) begin
            pending <= 1'b1;
         end
      end
   end

`ifdef SPI_ADC_RX_OVERRUN_EN
   //---------------------------------------------------------------------------
   // Sticky overrun: set when a trigger arrives while busy and one is already
   // held, i.e. whenever a trigger is dropped.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (state != ST_IDLE && trigger && pending) begin
         overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_adc_rx.sv
//------------------------------------------------------------------------------
// tb_spi_adc_rx
// Self-checking bench for spi_adc_rx with the default parameter set.
// A behavioural ADC drives miso from a stored word. A passive monitor counts
// nCS-low cycles, sck rises, valid pulses and busy cycles, and records frame
// start times. Expected values come from the frame-timing formulas and a
// word-level sample model: (word >> DATA_SHIFT) truncated to DATA_BITS.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_adc_rx;

   localparam int DIV        = 2;
   localparam int FRAME_BITS = 16;
   localparam int DATA_BITS  = 13;
   localparam int DATA_SHIFT = 3;
   localparam int GAP        = 4;
   localparam int PERIOD     = 100;

   localparam int NCS_LOW  = DIV * (1 + 2 * FRAME_BITS);   // 66
   localparam int BUSY_LEN = NCS_LOW + GAP;                // 70

   logic                 clk     = 1'b0;
   logic                 rst     = 1'b1;
   logic                 start   = 1'b0;
   logic                 auto_en = 1'b0;
   logic                 nCS;
   logic                 sck;
   logic                 miso;
   logic [DATA_BITS-1:0] dout;
   logic                 valid;
   logic                 busy;
`ifdef SPI_ADC_RX_OVERRUN_EN
   logic                 overrun;
`endif

   always #5 clk = ~clk;

   spi_adc_rx #(
      .DIV(DIV), .FRAME_BITS(FRAME_BITS), .DATA_BITS(DATA_BITS),
      .DATA_SHIFT(DATA_SHIFT), .GAP(GAP), .PERIOD(PERIOD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
      .nCS(nCS), .sck(sck), .miso(miso), .dout(dout),
      .valid(valid), .busy(busy)
`ifdef SPI_ADC_RX_OVERRUN_EN
      , .overrun(overrun)
`endif
   );

   //---------------------------------------------------------------------------
   // Check bookkeeping
   //---------------------------------------------------------------------------
   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
   endtask

   // Word-level reference: which bits of the received word end up on dout.
   function automatic logic [DATA_BITS-1:0] expected_sample(input logic [FRAME_BITS-1:0] word);
      logic [FRAME_BITS-1:0] shifted;
      shifted = word >> DATA_SHIFT;
      return shifted[DATA_BITS-1:0];
   endfunction

   //---------------------------------------------------------------------------
   // ADC model: loads its word when nCS falls and presents the next bit after
   // every sck rising edge, MSB first.
   //---------------------------------------------------------------------------
   logic [FRAME_BITS-1:0] dev_word = '0;
   logic [FRAME_BITS-1:0] dev_sr   = '0;

   always @(negedge nCS or posedge sck) begin
      if (sck) dev_sr = dev_sr << 1;
      else     dev_sr = dev_word;
   end
   assign miso = dev_sr[FRAME_BITS-1];

   //---------------------------------------------------------------------------
   // Passive monitor, sampled on the falling clk edge
   //---------------------------------------------------------------------------
   int cyc           = 0;
   int ncs_low_cnt   = 0;
   int sck_rise_cnt  = 0;
   int valid_cnt     = 0;
   int busy_cnt      = 0;
   int valid_bad_cnt = 0;   // valid pulses not aligned with an nCS rise
   int last_rise_cyc = -1000;
   int starts[$];
   int gaps[$];
   logic ncs_prev = 1'b1;
   logic sck_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!nCS) ncs_low_cnt++;
      if (sck && !sck_prev) sck_rise_cnt++;
      if (busy) busy_cnt++;
      if (valid) begin
         valid_cnt++;
         if (!(nCS && !ncs_prev)) valid_bad_cnt++;
      end
      if (!nCS && ncs_prev) begin
         starts.push_back(cyc);
         gaps.push_back(cyc - last_rise_cyc);
      end
      if (nCS && !ncs_prev) last_rise_cyc = cyc;
      ncs_prev = nCS;
      sck_prev = sck;
   end

   typedef struct {
      int ncs;
      int rises;
      int valids;
      int busys;
      int bad;
      int nstarts;
   } snap_t;

   function automatic snap_t take();
      snap_t s;
      s.ncs     = ncs_low_cnt;
      s.rises   = sck_rise_cnt;
      s.valids  = valid_cnt;
      s.busys   = busy_cnt;
      s.bad     = valid_bad_cnt;
      s.nstarts = starts.size();
      return s;
   endfunction

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      #1;
      check("wait_idle_timeout", busy, 1'b0);
   endtask

   task automatic run_frame(input logic [FRAME_BITS-1:0] word);
      dev_word = word;
      pulse_start();
      wait_idle(4 * BUSY_LEN);
   endtask

   typedef struct {
      logic [FRAME_BITS-1:0] word;
      logic [DATA_BITS-1:0]  exp_dout;
   } vec_t;

   //---------------------------------------------------------------------------
   // Watchdog
   //---------------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin
      vec_t  vecs[7];
      snap_t s0, s1;
      int    c_set;
      int    i0;
      logic [FRAME_BITS-1:0] w;

      vecs[0] = '{16'hA5A8, 13'h14B5};
      vecs[1] = '{16'hFFFF, 13'h1FFF};
      vecs[2] = '{16'h0000, 13'h0000};
      vecs[3] = '{16'h0007, 13'h0000};
      vecs[4] = '{16'h0008, 13'h0001};
      vecs[5] = '{16'h8000, 13'h1000};
      vecs[6] = '{16'h5555, 13'h0AAA};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ncs",   nCS,   1'b1);
      check("rst_sck",   sck,   1'b0);
      check("rst_dout",  dout,  '0);
      check("rst_valid", valid, 1'b0);
      check("rst_busy",  busy,  1'b0);
`ifdef SPI_ADC_RX_OVERRUN_EN
      check("rst_overrun", overrun, 1'b0);
`endif
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);

      // Single frame with the reference word 0xA5A8
      s0 = take();
      run_frame(16'hA5A8);
      s1 = take();
      check("single_ncs_low",   s1.ncs - s0.ncs,       NCS_LOW);
      check("single_sck_rises", s1.rises - s0.rises,   FRAME_BITS);
      check("single_valids",    s1.valids - s0.valids, 1);
      check("single_busy",      s1.busys - s0.busys,   BUSY_LEN);
      check("single_dout",      dout,                  13'h14B5);
      check("single_align",     s1.bad - s0.bad,       0);

      // Table vectors: includes all-ones followed by all-zeros
      for (int i = 0; i < 7; i++) begin
         s0 = take();
         run_frame(vecs[i].word);
         s1 = take();
         check($sformatf("vec%0d_dout", i),   dout,                  vecs[i].exp_dout);
         check($sformatf("vec%0d_valid", i),  s1.valids - s0.valids, 1);
         check($sformatf("vec%0d_ncs", i),    s1.ncs - s0.ncs,       NCS_LOW);
         check($sformatf("vec%0d_align", i),  s1.bad - s0.bad,       0);
      end

      // Random words against the reference model
      for (int i = 0; i < 8; i++) begin
         w = FRAME_BITS'($urandom);
         s0 = take();
         run_frame(w);
         s1 = take();
         check($sformatf("rand%0d_dout", i),  dout,                  expected_sample(w));
         check($sformatf("rand%0d_rises", i), s1.rises - s0.rises,   FRAME_BITS);
      end

      // Auto mode held for 1000 cycles
      dev_word = 16'h3C5A;
      s0 = take();
      i0 = starts.size();
      @(posedge clk); #1 auto_en = 1'b1;
      c_set = cyc;
      repeat (1000) @(posedge clk);
      #1 auto_en = 1'b0;
      wait_idle(4 * BUSY_LEN);
      s1 = take();
      check("auto_valids", s1.valids - s0.valids,   10);
      check("auto_starts", s1.nstarts - s0.nstarts, 10);
      check("auto_dout",   dout,                    expected_sample(16'h3C5A));
      if (starts.size() > i0) check("auto_first_start", starts[i0] - c_set, 2);
      for (int k = i0 + 1; k < starts.size(); k++) begin
         check($sformatf("auto_period%0d", k - i0), starts[k] - starts[k-1], PERIOD);
         check($sformatf("auto_gap%0d", k - i0),    gaps[k] >= GAP,          1'b1);
      end

      // start in the same cycle as the first auto tick counts once
      s0 = take();
      i0 = starts.size();
      @(posedge clk); #1 auto_en = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (148) @(posedge clk);
      #1 auto_en = 1'b0;
      repeat (120) @(negedge clk);
      s1 = take();
      check("merge_starts", s1.nstarts - s0.nstarts, 2);
      if (starts.size() >= i0 + 2) check("merge_period", starts[i0+1] - starts[i0], PERIOD);
`ifdef SPI_ADC_RX_OVERRUN_EN
      check("overrun_clear", overrun, 1'b0);
`endif

      // Retriggers at frame cycles 10, 30, 40: one pending frame, rest dropped
      dev_word = 16'h1234;
      s0 = take();
      i0 = starts.size();
      pulse_start();
      repeat (8)  @(posedge clk);
      pulse_start();
      repeat (19) @(posedge clk);
      pulse_start();
      repeat (9)  @(posedge clk);
      pulse_start();
      repeat (250) @(negedge clk);
      s1 = take();
      check("pend_valids", s1.valids - s0.valids,   2);
      check("pend_starts", s1.nstarts - s0.nstarts, 2);
      check("pend_dout",   dout,                    expected_sample(16'h1234));
      if (gaps.size() >= i0 + 2) check("pend_gap", gaps[i0+1], GAP + 1);
`ifdef SPI_ADC_RX_OVERRUN_EN
      check("overrun_set", overrun, 1'b1);
`endif

      // Reset in the middle of SHIFT
      dev_word = 16'hFFFF;
      pulse_start();
      repeat (20) @(posedge clk);
      #2;
      check("pre_rst_ncs", nCS, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("midrst_ncs",   nCS,   1'b1);
      check("midrst_sck",   sck,   1'b0);
      check("midrst_dout",  dout,  '0);
      check("midrst_valid", valid, 1'b0);
      check("midrst_busy",  busy,  1'b0);
`ifdef SPI_ADC_RX_OVERRUN_EN
      check("midrst_overrun", overrun, 1'b0);
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      s0 = take();
      repeat (150) @(negedge clk);
      s1 = take();
      check("postrst_valids", s1.valids - s0.valids,   0);
      check("postrst_starts", s1.nstarts - s0.nstarts, 0);
      check("postrst_dout",   dout,                    '0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
